fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the data word width, equal to the shared FIFO width.
REQ-003 Parameter BURST, default 4, SHALL set the maximum consecutive writes per grant (1..16).
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 req  in  NREQ  SHALL carry per-requester write-valid bits.
REQ-007 req_data  in  NREQ*WIDTH  SHALL carry requester i's word at bits [i*WIDTH +: WIDTH].
REQ-008 ack  out  NREQ  SHALL be one-hot or zero, marking the requester whose word is written this cycle.
REQ-009 fifo_full  in  1  SHALL be driven by the shared FIFO full flag.
REQ-010 fifo_wr_error  in  1  SHALL be driven by the shared FIFO write-error flag.
REQ-011 fifo_wr_en  out  1  SHALL be the FIFO write enable.
REQ-012 fifo_wr_data  out  WIDTH  SHALL be the FIFO write data.
REQ-013 owner  out  clog2(NREQ)  SHALL report the current or most recent grant holder.
REQ-014 busy  out  1  SHALL be high while in state BURST.
REQ-015 err_sticky  out  1  SHALL latch any fifo_wr_error.

Function
REQ-016 Writes SHALL be zero-latency: fifo_wr_en = |ack; fifo_wr_data = req_data slice of the acked requester, else all zeros.
REQ-017 ack[i] SHALL be asserted only if req[i]=1, fifo_full=0, rst=0 and i is the selected requester.
REQ-018 FSM states SHALL be IDLE and BURST.
REQ-019 In IDLE with any req and fifo_full=0, the first requester at or after rr_ptr (wrapping modulo NREQ) SHALL win, be acked this cycle, load owner and set cnt=1.
REQ-020 From IDLE after a grant, the FSM SHALL enter BURST if BURST>1; otherwise stay IDLE with rr_ptr = winner+1 mod NREQ.
REQ-021 In IDLE with fifo_full=1, no ack SHALL be issued and state SHALL not change.
REQ-022 In BURST with req[owner]=1 and fifo_full=0, owner SHALL be acked and cnt SHALL be incremented.
REQ-023 The FSM SHALL return to IDLE when the ack raises cnt to BURST, setting rr_ptr = owner+1 mod NREQ; the next arbitration SHALL occur in the following cycle with no bubble.
REQ-024 In BURST with req[owner]=0, no ack SHALL be issued, the FSM SHALL go IDLE and rr_ptr SHALL become owner+1 mod NREQ, giving one idle cycle.
REQ-025 In BURST with fifo_full=1 and req[owner]=1, the FSM SHALL stall: no ack, cnt held, owner retained.
REQ-026 Non-owner requests SHALL be ignored in BURST.
REQ-027 err_sticky SHALL be set in the cycle after fifo_wr_error=1 and SHALL be cleared only by rst.
REQ-028 Because fifo_wr_en is never asserted while fifo_full=1, err_sticky=1 SHALL indicate an external fault.

Reset
REQ-029 While rst=1: state=IDLE, rr_ptr=0, owner=0, cnt=0, err_sticky=0, ack=0, fifo_wr_en=0, busy=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately, with no ack in any cycle where rst=1.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default NREQ/WIDTH/BURST constants.
REQ-032 Sub-module rr_pick SHALL implement the combinational rotating-priority first-one finder (inputs req and rr_ptr; outputs index and valid).

Verification
REQ-033 Only req[2] high for 6 cycles, BURST=4, FIFO empty -> 4 acks to 2, then 2 more acks in the next grant, 6 FIFO words in order, owner=2.
REQ-034 req=4'b1111 held, BURST=4 -> grant order 0,1,2,3,0 with 4 writes each; first write lands in the cycle after rst deasserts.
REQ-035 req[1] in BURST with fifo_full forced high for 3 cycles after the 2nd write -> no ack for 3 cycles, cnt held, burst completes with writes 3 and 4, busy high throughout.
REQ-036 req[0] drops after 2 writes while req[3]=1 -> one idle cycle, then req[3] granted; 0 receives no third ack.
REQ-037 Drive 20 writes from requester 1 into a 16-deep FIFO with no reads -> exactly 16 acks, then ack=0 while full, err_sticky stays 0.
REQ-038 rst pulsed during a burst at cnt=2 -> outputs zero during rst; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Holds the FSM state enum and default NREQ/WIDTH/BURST values.
package fifo_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority first-one finder: scans req starting at rr_ptr.
// Ports: req (request bits), rr_ptr (start index), index (winner), valid (any req).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   index,
  output logic            valid
);

  int          w_j;
  logic [IW-1:0] w_jj;

  // Walk NREQ positions from rr_ptr, wrapping modulo NREQ
  // (NREQ need not be a power of two).
  always_comb begin
    index = '0;
    valid = 1'b0;
    w_j   = 0;
    w_jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(rr_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      w_jj = IW'(w_j);
      if (!valid && req[w_jj]) begin
        valid = 1'b1;
        index = w_jj;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter granting NREQ writers access to one FIFO.
// Ports: clk, rst; req/req_data in; ack, fifo_wr_en/data, owner, busy, err_sticky out.
module fifo_wr_arbiter #(
  parameter int NREQ  = fifo_arb_pkg::DEF_NREQ,
  parameter int WIDTH = fifo_arb_pkg::DEF_WIDTH,
  parameter int BURST = fifo_arb_pkg::DEF_BURST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  input  logic                    fifo_full,
  input  logic                    fifo_wr_error,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_wr_data,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    err_sticky
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST);

  fifo_arb_pkg::state_t r_state, w_state_nx;

  logic [IW-1:0]    r_ptr, w_ptr_nx;
  logic [IW-1:0]    r_owner, w_owner_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [CW-1:0]    w_cnt_inc;
  logic             r_err;
  logic [NREQ-1:0]  w_ack;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_vld;
  logic [WIDTH-1:0] w_data;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (r_ptr),
    .index  (w_pick_idx),
    .valid  (w_pick_vld)
  );

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_ack      = '0;
    unique case (r_state)
      fifo_arb_pkg::IDLE: begin
        if (w_pick_vld && !fifo_full) begin
          w_ack[w_pick_idx] = 1'b1;
          w_owner_nx        = w_pick_idx;
          w_cnt_nx          = CW'(1);
          if (BURST > 1) w_state_nx = fifo_arb_pkg::BURST;
          else           w_ptr_nx   = inc_mod(w_pick_idx);
        end
      end
      fifo_arb_pkg::BURST: begin
        if (!req[r_owner]) begin
          // Owner went quiet: give up the grant, costs one idle cycle.
          w_state_nx = fifo_arb_pkg::IDLE;
          w_ptr_nx   = inc_mod(r_owner);
        end else if (!fifo_full) begin
          w_ack[r_owner] = 1'b1;
          w_cnt_nx       = w_cnt_inc;
          if (w_cnt_inc == CMAX) begin
            w_state_nx = fifo_arb_pkg::IDLE;
            w_ptr_nx   = inc_mod(r_owner);
          end
        end
      end
      default: begin
        w_state_nx = fifo_arb_pkg::IDLE;
      end
    endcase
    // Reset is asynchronous, so gate acks combinationally too.
    if (rst) w_ack = '0;
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_ack[i]) w_data = w_data | req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= fifo_arb_pkg::IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_owner <= w_owner_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= r_err | fifo_wr_error;
    end
  end

  assign ack          = w_ack;
  assign fifo_wr_en   = |w_ack;
  assign fifo_wr_data = w_data;
  assign owner        = r_owner;
  assign busy         = (r_state == fifo_arb_pkg::BURST);
  assign err_sticky   = r_err;

endmodule
